ib_fifo_sub: RTL and testbench
==============================

// Module: ib_fifo_sub
// PURPOSE
//   Per-port input buffer of a mesh router. Accepts flits from the upstream
//   link, holds them in a DEPTH-entry FIFO and presents the head flit to the
//   route-computation stage with a valid/ready handshake. Publishes its
//   occupancy as a pressure count, which neighbouring routers use for
//   adaptive direction choice.
// PARAMETERS
//   DEPTH    8   FIFO entries; must equal 2**WIDTH
//   WIDTH    3   pointer width; the occupancy/pressure count is WIDTH+1 bits
//   DATASIZE 40  flit width: src[39:36] dst[35:32] ts[31:24] data[23:2] type[1:0]
// PORTS
//   ib_clk        in   1           clock; single clock domain
//   rst_n         in   1           asynchronous active-low reset
//   data_in       in   DATASIZE    flit from the upstream link
//   valid_in      in   1           data_in holds a flit
//   ready_out     out  1           buffer can accept a flit this cycle (not full)
//   data_out      out  DATASIZE    head flit to route computation
//   valid_out     out  1           data_out holds a valid head flit (not empty)
//   rc_ready      in   1           route computation takes the head flit this cycle
//   pressure_out  out  WIDTH+1     current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (async, rst_n=0): wr_ptr=rd_ptr=0, count=0, pressure_out=0,
//     valid_out=0, ready_out=1, data_out=0. Storage contents are not reset.
//     Reset during traffic discards all stored flits immediately.
//   - push = valid_in & ready_out; pop = valid_out & rc_ready.
//   - ready_out = (count != DEPTH); valid_out = (count != 0). Both are
//     decoded from the registered count and are combinationally independent
//     of valid_in and rc_ready (no comb path from input to output).
//   - Push writes mem[wr_ptr] at the ib_clk edge, then wr_ptr+1. Pop advances
//     rd_ptr+1. Pointers wrap DEPTH-1 -> 0 naturally (WIDTH bits).
//   - count: push only -> +1; pop only -> -1; both or neither -> unchanged.
//   - data_out = mem[rd_ptr] when valid_out = 1, else 0 (show-ahead). Latency
//     from push into an empty FIFO to valid_out=1: 1 cycle.
//   - Full (count=DEPTH): ready_out=0, so no push, even if a pop happens in
//     the same cycle. ready_out goes back to 1 in the cycle after the pop.
//   - Empty (count=0): valid_out=0, and rc_ready is ignored. There is no
//     fall-through bypass: a flit pushed in cycle N can be popped in N+1
//     at the earliest.
//   - Simultaneous push and pop at 0 < count < DEPTH: both happen, and count
//     holds.
//   - Upstream holds data_in/valid_in until ready_out=1. The buffer never
//     drops or duplicates a flit. Order is strict FIFO.
//   - pressure_out = count, registered and updated at the same edge as count.
//   - Flit contents pass through unmodified. No field is decoded here.
// STRUCTURE
//   - Shared package noc_pkg: DATASIZE, field slices (SRC_MSB/LSB,
//     DST_MSB/LSB, TS, DATA, TYPE), direction one-hot codes
//     N=1000 E=0100 S=0010 W=0001 NONE=1111, and type codes.
//   - One sub-module, ib_fifo_mem: DEPTH x DATASIZE register array with
//     1 write port and 1 async read port. Pointers, count and handshake
//     logic live in ib_fifo_sub.
// TESTING
//   1. Reset with rst_n=0 mid-burst -> valid_out=0, ready_out=1,
//      pressure_out=0 right away (asynchronously). After release, the first
//      new flit comes out first.
//   2. Push 0x11_0000_0001..0x11_0000_0008 with rc_ready=0 -> pressure_out
//      steps 1..8; ready_out=0 after the 8th push. A 9th valid_in is held
//      and not accepted.
//   3. Full, then rc_ready=1 for 8 cycles -> flits come out in push order;
//      pressure_out 8..0; valid_out=0 after the last pop.
//   4. count=3, with valid_in=1 and rc_ready=1 for 10 cycles -> pressure_out
//      stays 3; output order matches input order across the pointer wrap.
//   5. Full with valid_in=1 and rc_ready=1 in the same cycle -> pop only;
//      pressure_out=7; the held flit is accepted on the next cycle.
//   6. Empty, push at cycle N with rc_ready=1 held -> valid_out=1 at N+1;
//      popped at N+1; pressure_out goes 0 -> 1 -> 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit layout, direction
// and flit-type codes, default input-buffer geometry.
package noc_pkg;

  localparam int DATASIZE   = 40;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_WIDTH = 3;

  localparam int SRC_MSB  = 39;
  localparam int SRC_LSB  = 36;
  localparam int DST_MSB  = 35;
  localparam int DST_LSB  = 32;
  localparam int TS_MSB   = 31;
  localparam int TS_LSB   = 24;
  localparam int DATA_MSB = 23;
  localparam int DATA_LSB = 2;
  localparam int TYPE_MSB = 1;
  localparam int TYPE_LSB = 0;

  typedef enum logic [3:0] {
    DIR_N    = 4'b1000,
    DIR_E    = 4'b0100,
    DIR_S    = 4'b0010,
    DIR_W    = 4'b0001,
    DIR_NONE = 4'b1111
  } dir_e;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef logic [DATASIZE-1:0] flit_t;

  function automatic logic [3:0] flit_dst(
    input flit_t f
  );
    return f[DST_MSB:DST_LSB];
  endfunction

endpackage

// File: rtl/ib_fifo_mem.sv
// Input-buffer storage: DEPTH x DW register array,
// one synchronous write port and one async read port.
module ib_fifo_mem
  import noc_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DW    = DATASIZE
) (
  input  logic             ib_clk,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [WIDTH-1:0] rd_addr,
  output logic [DW-1:0]    rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge ib_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ib_fifo_sub.sv
// Router input buffer: show-ahead FIFO with valid/ready
// handshakes and a registered occupancy (pressure) count.
module ib_fifo_sub
  import noc_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                ib_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                rc_ready,
  output logic [WIDTH:0]      pressure_out
);

  localparam logic [WIDTH:0]   FULL    = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0]   CNT_ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] PTR_ONE = WIDTH'(1);

  logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0]      count_q, count_d;
  logic [WIDTH:0]      pressure_q, pressure_d;
  logic                push, pop;
  logic [DATASIZE-1:0] rd_data;

  // Handshakes decode only registered state.
  assign ready_out = (count_q != FULL);
  assign valid_out = (count_q != '0);
  assign push      = valid_in & ready_out;
  assign pop       = valid_out & rc_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    pressure_d = count_d;
  end

  always_ff @(posedge ib_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pressure_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pressure_q <= pressure_d;
    end
  end

  ib_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .DW    (DATASIZE)
  ) u_mem (
    .ib_clk  (ib_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign data_out     = valid_out ? rd_data : '0;
  assign pressure_out = pressure_q;

endmodule

// File: tb/tb_ib_fifo_sub.sv
// Scoreboard bench for ib_fifo_sub: driver queues accepted
// flits, a negedge monitor checks every popped head flit.
module tb_ib_fifo_sub;

  logic        ib_clk = 1'b0;
  logic        rst_n;
  logic [39:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [39:0] data_out;
  logic        valid_out;
  logic        rc_ready;
  logic [3:0]  pressure_out;

  int checks = 0;
  int errors = 0;
  logic [39:0] sb_q[$];
  logic acc;

  always #5 ib_clk = ~ib_clk;

  ib_fifo_sub dut (
    .ib_clk       (ib_clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .rc_ready     (rc_ready),
    .pressure_out (pressure_out)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive just after posedge, decide accept at
  // negedge, return just after the next posedge.
  task automatic step(input logic vin,
                      input logic [39:0] din,
                      input logic rdy,
                      output logic accepted);
    valid_in = vin;
    data_in  = din;
    rc_ready = rdy;
    @(negedge ib_clk);
    accepted = vin && ready_out;
    if (accepted) sb_q.push_back(din);
    @(posedge ib_clk);
    #1;
  endtask

  always @(negedge ib_clk) begin
    if (rst_n) begin
      if (valid_out && rc_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_unexpected", 64'(data_out), 64'hdead);
        end else begin
          chk("pop_data", 64'(data_out), 64'(sb_q.pop_front()));
        end
      end else if (!valid_out) begin
        chk("idle_data_zero", 64'(data_out), 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    rc_ready = 1'b0;
    data_in  = '0;
    #1;
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_ready", 64'(ready_out), 64'h1);
    chk("rst_press", 64'(pressure_out), 64'h0);
    chk("rst_data", 64'(data_out), 64'h0);
    repeat (2) @(posedge ib_clk);
    #1 rst_n = 1'b1;

    // Fill with flow stopped: pressure 1..8, then full.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 40'h11_0000_0000 | 40'(i), 1'b0, acc);
      chk("fill_acc", 64'(acc), 64'h1);
      chk("fill_press", 64'(pressure_out), 64'(i));
    end
    chk("full_ready", 64'(ready_out), 64'h0);
    step(1'b1, 40'h11_0000_0009, 1'b0, acc);
    chk("ninth_held", 64'(acc), 64'h0);
    chk("ninth_press", 64'(pressure_out), 64'h8);

    // Drain in order: pressure 7..0.
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, '0, 1'b1, acc);
      chk("drain_press", 64'(pressure_out), 64'(i));
    end
    chk("drain_valid", 64'(valid_out), 64'h0);

    // Push into empty with rc_ready held: no fall-through.
    step(1'b1, 40'h33_0000_00aa, 1'b1, acc);
    chk("e_acc", 64'(acc), 64'h1);
    chk("e_press1", 64'(pressure_out), 64'h1);
    chk("e_valid", 64'(valid_out), 64'h1);
    step(1'b0, '0, 1'b1, acc);
    chk("e_press0", 64'(pressure_out), 64'h0);

    // count=3 then streaming push+pop across the wrap.
    for (int i = 0; i < 3; i++)
      step(1'b1, 40'h22_0000_0000 | 40'(i), 1'b0, acc);
    chk("s_press3", 64'(pressure_out), 64'h3);
    for (int i = 3; i < 13; i++) begin
      step(1'b1, 40'h22_0000_0000 | 40'(i), 1'b1, acc);
      chk("s_acc", 64'(acc), 64'h1);
      chk("s_press", 64'(pressure_out), 64'h3);
    end
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, 1'b1, acc);
    chk("s_empty", 64'(pressure_out), 64'h0);

    // Full with push and pop together: pop only.
    for (int i = 0; i < 8; i++)
      step(1'b1, 40'h44_0000_0000 | 40'(i), 1'b0, acc);
    chk("f_press8", 64'(pressure_out), 64'h8);
    step(1'b1, 40'h44_0000_0008, 1'b1, acc);
    chk("f_no_push", 64'(acc), 64'h0);
    chk("f_press7", 64'(pressure_out), 64'h7);
    chk("f_ready", 64'(ready_out), 64'h1);
    step(1'b1, 40'h44_0000_0008, 1'b0, acc);
    chk("f_held_acc", 64'(acc), 64'h1);
    chk("f_press8b", 64'(pressure_out), 64'h8);
    for (int i = 0; i < 8; i++)
      step(1'b0, '0, 1'b1, acc);
    chk("f_empty", 64'(pressure_out), 64'h0);

    // Async reset in the middle of a burst.
    for (int i = 0; i < 3; i++)
      step(1'b1, 40'h55_0000_0000 | 40'(i), 1'b0, acc);
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(valid_out), 64'h0);
    chk("ar_ready", 64'(ready_out), 64'h1);
    chk("ar_press", 64'(pressure_out), 64'h0);
    chk("ar_data", 64'(data_out), 64'h0);
    sb_q.delete();
    @(posedge ib_clk);
    #1 rst_n = 1'b1;
    step(1'b1, 40'h66_0000_00bb, 1'b0, acc);
    step(1'b1, 40'h66_0000_00cc, 1'b1, acc);
    chk("ar_head", 64'(data_out), 64'h66_0000_00cc);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b0, acc);
    chk("end_press", 64'(pressure_out), 64'h0);
    chk("end_sb_empty", 64'(sb_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
